// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - issue/writeback sequencer wrapped around the 16-bit ALU
module alu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done_valid,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              done_err,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   res_q;
  logic                z_q;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   rf_a, rf_b;
  logic                accept, legal;

  assign accept = instr_valid && instr_ready;
  assign legal  = (op_q != OP_ILLEGAL);

  // Register-file read ports; r0 is hardwired to zero on every read path.
  always_comb begin
    rf_a     = '0;
    rf_b     = '0;
    dbg_data = '0;
    if (rs1_q != '0)    rf_a     = regs[rs1_q];
    if (rs2_q != '0)    rf_b     = regs[rs2_q];
    if (dbg_addr != '0) dbg_data = regs[dbg_addr];
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Fixed four-step sequence plus the handshake and completion outputs.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done_valid  = 1'b0;
    done_err    = 1'b0;
    done_rd     = rd_q;
    done_data   = res_q;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done_valid = 1'b1;
        done_err   = !legal;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the whole instruction at the handshake; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
    end else if (accept) begin
      op_q      <= instr_op;
      rd_q      <= instr_rd;
      rs1_q     <= instr_rs1;
      rs2_q     <= instr_rs2;
      use_imm_q <= instr_use_imm;
      imm_q     <= instr_imm;
    end
  end

  // Operand registers double as the ALU drive; held until the next READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 3'b000;
    end else if (state_q == S_READ) begin
      alu_a    <= rf_a;
      alu_b    <= use_imm_q ? imm_q : rf_b;
      alu_ctrl <= op_q;
    end
  end

  // ALU result and zero are sampled at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q <= alu_result;
      z_q   <= alu_zero;
    end
  end

  // Writeback and flag update leaving WB; illegal ops change no architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state_q == S_WB && legal) begin
      if (rd_q != '0) regs[rd_q] <= res_q;
      flag_z <= z_q;
      flag_n <= res_q[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - scoreboard bench for alu_exec_ctrl with a behavioural ALU
module tb_alu_exec_ctrl;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [REG_AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic              instr_use_imm;
  logic [DATA_W-1:0] instr_imm;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]        alu_ctrl;
  logic              alu_zero;
  logic              done_valid;
  logic [REG_AW-1:0] done_rd;
  logic [DATA_W-1:0] done_data;
  logic              done_err;
  logic              flag_z, flag_n;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  typedef struct {
    logic [2:0]        rd;
    logic [DATA_W-1:0] data;
    logic              err;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } exp_t;

  exp_t              sbq[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] mregs [NREG];
  logic              mz, mn;
  int                assertions = 0;
  int                failures   = 0;
  int                done_cnt   = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data), .done_err(done_err),
    .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      3'd0:    return a - b;
      3'd1:    return a + b;
      3'd2:    return p[DATA_W-1:0];
      3'd3:    return a / 16'd3;
      3'd4:    return a & b;
      3'd5:    return {a[DATA_W-2:0], 1'b0};
      3'd6:    return {1'b0, a[DATA_W-1:1]};
      default: return 16'hDEAD;
    endcase
  endfunction

  assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mz = 1'b0;
    mn = 1'b0;
    sbq.delete();
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic ui, input logic [DATA_W-1:0] imm,
                            output exp_t e);
    e.a    = (rs1 == 3'd0) ? 16'h0 : mregs[rs1];
    e.b    = ui ? imm : ((rs2 == 3'd0) ? 16'h0 : mregs[rs2]);
    e.op   = op;
    e.data = alu_f(op, e.a, e.b);
    e.rd   = rd;
    e.err  = (op == 3'b111);
    sbq.push_back(e);
    if (op != 3'b111) begin
      if (rd != 3'd0) mregs[rd] = e.data;
      mz = (e.data == 16'h0);
      mn = e.data[DATA_W-1];
    end
  endtask

  // Completion monitor: every WB pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done_valid) begin
      assertions++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: done_valid=1 rd=%0d data=%h, required no completion", done_rd, done_data);
      end else begin
        mon_e = sbq.pop_front();
        if ({done_rd, done_data, done_err} !== {mon_e.rd, mon_e.data, mon_e.err}) begin
          failures++;
          $display("FAIL done_fields: rd=%0d data=%h err=%b, required rd=%0d data=%h err=%b",
                   done_rd, done_data, done_err, mon_e.rd, mon_e.data, mon_e.err);
        end
        assertions++;
        if ({alu_a, alu_b, alu_ctrl} !== {mon_e.a, mon_e.b, mon_e.op}) begin
          failures++;
          $display("FAIL alu_hold_wb: a=%h b=%h ctrl=%0d, required a=%h b=%h ctrl=%0d",
                   alu_a, alu_b, alu_ctrl, mon_e.a, mon_e.b, mon_e.op);
        end
      end
      done_cnt++;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic ui, input logic [DATA_W-1:0] imm);
    exp_t e;
    int   n;
    int   start;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: instr_ready=%b, required 1", instr_ready);
    end
    start = done_cnt;
    model_exec(op, rd, rs1, rs2, ui, imm, e);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1;
    instr_rs2 = rs2; instr_use_imm = ui; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_op = ~op; instr_rd = ~rd; instr_rs1 = ~rs1;
    instr_rs2 = ~rs2; instr_use_imm = ~ui; instr_imm = ~imm;
    assertions++;
    if (instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_read: instr_ready=%b, required 0", instr_ready);
    end
    @(posedge clk); #1;
    assertions++;
    if ({alu_a, alu_b, alu_ctrl, done_valid, instr_ready} !== {e.a, e.b, e.op, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL alu_exec: a=%h b=%h ctrl=%0d dv=%b rdy=%b, required a=%h b=%h ctrl=%0d dv=0 rdy=0",
               alu_a, alu_b, alu_ctrl, done_valid, instr_ready, e.a, e.b, e.op);
    end
    @(posedge clk); #1;
    assertions++;
    if (done_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_wb: done_valid=%b, required 1", done_valid);
    end
    @(posedge clk); #1;
    assertions++;
    if ({instr_ready, done_valid, flag_z, flag_n} !== {1'b1, 1'b0, mz, mn}) begin
      failures++;
      $display("FAIL idle_flags: rdy=%b dv=%b z=%b n=%b, required rdy=1 dv=0 z=%b n=%b",
               instr_ready, done_valid, flag_z, flag_n, mz, mn);
    end
    assertions++;
    if (done_cnt != start + 1) begin
      failures++;
      $display("FAIL done_count: completions=%0d, required 1", done_cnt - start);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    assertions++;
    if ({instr_ready, done_valid, alu_a, alu_b, alu_ctrl, flag_z, flag_n} !== {1'b1, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy=%b dv=%b a=%h b=%h ctrl=%0d z=%b n=%b, required rdy=1 dv=0 a=0 b=0 ctrl=0 z=0 n=0",
               instr_ready, done_valid, alu_a, alu_b, alu_ctrl, flag_z, flag_n);
    end
    rst_n = 1'b1;
    #1;
    assertions++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: instr_ready=%b, required 1", instr_ready);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      assertions++;
      if (dbg_data !== 16'h0) begin
        failures++;
        $display("FAIL reset_reg r%0d: %h, required 0000", i, dbg_data);
      end
    end
  endtask

  task automatic check_reg(input logic [2:0] r, input logic [DATA_W-1:0] v, input string nm);
    dbg_addr = r;
    #1;
    assertions++;
    if (dbg_data !== v) begin
      failures++;
      $display("FAIL %s: r%0d=%h, required %h", nm, r, dbg_data, v);
    end
  endtask

  task automatic check_flags(input logic z, input logic n, input string nm);
    assertions++;
    if ({flag_z, flag_n} !== {z, n}) begin
      failures++;
      $display("FAIL %s: z=%b n=%b, required z=%b n=%b", nm, flag_z, flag_n, z, n);
    end
  endtask

  task automatic test_add();
    issue(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);
    check_reg(3'd1, 16'h0005, "add_r1");
    issue(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0007);
    check_reg(3'd2, 16'h000C, "add_r2");
    check_flags(1'b0, 1'b0, "add_flags");
  endtask

  task automatic test_sub();
    issue(3'd0, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0010);
    check_reg(3'd3, 16'hFFFC, "sub_neg");
    check_flags(1'b0, 1'b1, "sub_neg_flags");
    issue(3'd0, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0000);
    check_reg(3'd4, 16'h0000, "sub_zero");
    check_flags(1'b1, 1'b0, "sub_zero_flags");
  endtask

  task automatic test_alu_ops();
    issue(3'd2, 3'd6, 3'd1, 3'd0, 1'b1, 16'h4000);
    check_reg(3'd6, 16'h4000, "mul_low");
    issue(3'd3, 3'd6, 3'd2, 3'd0, 1'b0, 16'h0000);
    check_reg(3'd6, 16'h0004, "div3");
    issue(3'd1, 3'd7, 3'd0, 3'd0, 1'b1, 16'h8001);
    issue(3'd5, 3'd6, 3'd7, 3'd0, 1'b0, 16'h0000);
    check_reg(3'd6, 16'h0002, "shl");
    issue(3'd6, 3'd6, 3'd7, 3'd0, 1'b0, 16'h0000);
    check_reg(3'd6, 16'h4000, "shr");
    issue(3'd4, 3'd6, 3'd7, 3'd0, 1'b1, 16'h00FF);
    check_reg(3'd6, 16'h0001, "and");
  endtask

  task automatic test_illegal();
    logic z0, n0;
    issue(3'd1, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0055);
    z0 = flag_z;
    n0 = flag_n;
    issue(3'd7, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000);
    check_reg(3'd5, 16'h0055, "illegal_no_write");
    check_flags(z0, n0, "illegal_flags_kept");
  endtask

  task automatic test_r0_write();
    issue(3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0000);
    check_flags(1'b1, 1'b0, "pre_r0_flags");
    issue(3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);
    check_flags(1'b0, 1'b0, "r0_flags");
    check_reg(3'd0, 16'h0000, "r0_reads_zero");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   accepts;
    int   start;
    accepts = 0;
    @(negedge clk);
    start = done_cnt;
    instr_valid = 1'b1; instr_op = 3'd1; instr_rd = 3'd7; instr_rs1 = 3'd7;
    instr_rs2 = 3'd0; instr_use_imm = 1'b1; instr_imm = 16'h0001;
    for (int c = 0; c < 12; c++) begin
      assertions++;
      if (instr_ready !== ((c % 4) == 0)) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d: instr_ready=%b, required %b", c, instr_ready, (c % 4) == 0);
      end
      if (instr_ready) begin
        model_exec(3'd1, 3'd7, 3'd7, 3'd0, 1'b1, 16'h0001, e);
        accepts++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    assertions++;
    if (accepts != 3 || done_cnt - start != 3) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d completions=%0d, required 3 and 3", accepts, done_cnt - start);
    end
    check_reg(3'd7, 16'h8004, "b2b_r7");
  endtask

  task automatic test_reset_midflight();
    int start;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'd1; instr_rd = 3'd6; instr_rs1 = 3'd1;
    instr_rs2 = 3'd0; instr_use_imm = 1'b1; instr_imm = 16'h0001;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = done_cnt;
    #1;
    assertions++;
    if ({done_valid, instr_ready, alu_a, alu_ctrl, flag_z, flag_n} !== {1'b0, 1'b1, 16'h0, 3'b000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midflight_reset: dv=%b rdy=%b a=%h ctrl=%0d z=%b n=%b, required dv=0 rdy=1 a=0 ctrl=0 z=0 n=0",
               done_valid, instr_ready, alu_a, alu_ctrl, flag_z, flag_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    assertions++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midflight_ready: instr_ready=%b, required 1", instr_ready);
    end
    check_reg(3'd6, 16'h0000, "midflight_r6");
    check_reg(3'd1, 16'h0000, "midflight_r1");
    repeat (6) @(negedge clk);
    assertions++;
    if (done_cnt != start) begin
      failures++;
      $display("FAIL midflight_done: completions=%0d, required 0", done_cnt - start);
    end
    issue(3'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0003);
    check_reg(3'd1, 16'h0003, "post_reset_add");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_alu_ops();
    test_illegal();
    test_r0_write();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
